anton_neopixel_stream: RTL

- Parametrised successor NeoPixel (WS2812) serial driver with an APB-style byte register interface.
- Holds up to PIXELS_MAX full 24-bit pixels (8 bits each of G, R, B) and serialises a runtime-selectable number of them onto NEO_DATA.
- Bit timing and latch delay are parameters.
- Supports one-shot and continuous (loop) refresh modes, with busy/done status and a done pulse for the MSS.

---
 rtl/anton_neopixel_stream.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/anton_neopixel_stream.sv
// WS2812 pixel streamer: APB byte-mapped pixel buffer plus CTRL/LEN registers,
// serialising LEN pixels (GRB, MSB first) once or in a loop with a latch gap after each frame.
module anton_neopixel_stream #(
  parameter int PIXELS_MAX  = 64,
  parameter int PIXELS_BITS = 7,
  parameter int ADDR_BITS   = 8,
  parameter int BIT_TICKS   = 12,
  parameter int T0H_TICKS   = 3,
  parameter int T1H_TICKS   = 8,
  parameter int RESET_TICKS = 600
) (
  input  logic                 CLK_10MHZ,
  input  logic                 APB_PRESERN,
  input  logic [ADDR_BITS-1:0] APB_PADDR,
  input  logic                 APB_PSELx,
  input  logic                 APB_PENABLE,
  input  logic                 APB_PWRITE,
  input  logic [7:0]           APB_PWDATA,
  output logic [7:0]           APB_PRDATA,
  output logic                 APB_PREADY,
  output logic                 APB_PSLVERR,
  output logic                 NEO_DATA,
  output logic                 VERBOSE_STATE,
  output logic                 DONE_IRQ
);

  localparam int NBYTES = 3 * PIXELS_MAX;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int TICK_W = $clog2(BIT_TICKS);
  localparam int LAT_W  = $clog2(RESET_TICKS);

  localparam logic [ADDR_BITS-1:0]   CTRL_ADDR = {{(ADDR_BITS-1){1'b1}}, 1'b0};
  localparam logic [ADDR_BITS-1:0]   LEN_ADDR  = '1;
  localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0]      T0H       = TICK_W'(T0H_TICKS);
  localparam logic [TICK_W-1:0]      T1H       = TICK_W'(T1H_TICKS);
  localparam logic [LAT_W-1:0]       LAT_LAST  = LAT_W'(RESET_TICKS - 1);
  localparam logic [PIXELS_BITS-1:0] LEN_RST   = PIXELS_BITS'(PIXELS_MAX);
  localparam logic [PIXELS_BITS-1:0] PIX_ONE   = PIXELS_BITS'(1);
  localparam logic [4:0]             BIT_LAST  = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRANSMIT,
    S_LATCH
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             mem_q [NBYTES];
  logic [7:0]             mem_d [NBYTES];
  logic [PIXELS_BITS-1:0] len_q, len_d;
  logic                   loop_q, loop_d;
  logic                   done_q, done_d;
  logic                   irq_q, irq_d;
  logic [23:0]            shift_q, shift_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [4:0]             bit_q, bit_d;
  logic [PIXELS_BITS-1:0] pix_q, pix_d;
  logic [PIXELS_BITS-1:0] flen_q, flen_d;
  logic [LAT_W-1:0]       lat_q, lat_d;

  logic                   acc;
  logic                   wr_ok;
  logic                   is_pix;
  logic                   is_ctrl;
  logic                   is_len;
  logic                   len_ok;
  logic                   busy;
  logic                   start;
  logic                   done_clr;
  logic [IDX_W-1:0]       pix_idx;
  logic [PIXELS_BITS-1:0] ld_pix;
  logic [IDX_W-1:0]       ld_base;
  logic [23:0]            ld_word;

  // ---------------------------------------------------------------- APB decode
  assign acc     = APB_PSELx & APB_PENABLE;
  assign is_pix  = 32'(APB_PADDR) < 32'(NBYTES);
  assign is_ctrl = APB_PADDR == CTRL_ADDR;
  assign is_len  = APB_PADDR == LEN_ADDR;
  assign len_ok  = (APB_PWDATA != 8'd0) && (32'(APB_PWDATA) <= 32'(PIXELS_MAX));
  assign pix_idx = APB_PADDR[IDX_W-1:0];
  assign busy    = state_q != S_IDLE;

  assign APB_PREADY  = 1'b1;
  assign APB_PSLVERR = acc & (~(is_pix | is_ctrl | is_len) |
                              (APB_PWRITE & is_len & ~len_ok));
  assign wr_ok       = acc & APB_PWRITE & ~APB_PSLVERR;

  always_comb begin
    APB_PRDATA = 8'h00;
    if (APB_PSELx && !APB_PWRITE) begin
      if (is_pix)       APB_PRDATA = mem_q[pix_idx];
      else if (is_ctrl) APB_PRDATA = {busy, 4'b0000, done_q, loop_q, 1'b0};
      else if (is_len)  APB_PRDATA = 8'(len_q);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    len_d    = len_q;
    loop_d   = loop_q;
    start    = 1'b0;
    done_clr = 1'b0;
    if (wr_ok) begin
      if (is_pix) mem_d[pix_idx] = APB_PWDATA;
      if (is_ctrl) begin
        start    = APB_PWDATA[0];
        loop_d   = APB_PWDATA[1];
        done_clr = APB_PWDATA[2];
      end
      if (is_len) len_d = PIXELS_BITS'(APB_PWDATA);
    end
  end

  // Pixel fetch reads the post-write buffer so a byte written on the load cycle still lands.
  always_comb begin
    ld_pix = (state_q == S_TRANSMIT) ? pix_q + PIX_ONE : '0;
    if (32'(ld_pix) >= 32'(PIXELS_MAX)) ld_pix = '0;
    ld_base = IDX_W'(3 * 32'(ld_pix));
    ld_word = {mem_d[ld_base], mem_d[ld_base + IDX_W'(1)], mem_d[ld_base + IDX_W'(2)]};
  end

  // ---------------------------------------------------------------- serialiser
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    flen_d  = flen_q;
    lat_d   = lat_q;
    done_d  = done_q;
    irq_d   = 1'b0;
    if (done_clr) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRANSMIT;
          shift_d = ld_word;
          tick_d  = '0;
          bit_d   = '0;
          pix_d   = '0;
          flen_d  = len_q;
        end
      end
      S_TRANSMIT: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (pix_q == flen_q - PIX_ONE) begin
              state_d = S_LATCH;
              lat_d   = '0;
            end else begin
              pix_d   = pix_q + PIX_ONE;
              shift_d = ld_word;
            end
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_LATCH: begin
        if (lat_q == LAT_LAST) begin
          if (loop_q) begin
            state_d = S_TRANSMIT;
            flen_d  = len_q;
            pix_d   = '0;
            tick_d  = '0;
            bit_d   = '0;
            shift_d = ld_word;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            irq_d   = 1'b1;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_10MHZ or negedge APB_PRESERN) begin
    if (!APB_PRESERN) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NBYTES; i++) mem_q[i] <= 8'h00;
      len_q   <= LEN_RST;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      shift_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      flen_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      shift_q <= shift_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      flen_q  <= flen_d;
      lat_q   <= lat_d;
    end
  end

  // Output is decoded straight from state flops so reset drops the line without a clock.
  assign NEO_DATA      = (state_q == S_TRANSMIT) && (tick_q < (shift_q[23] ? T1H : T0H));
  assign VERBOSE_STATE = busy;
  assign DONE_IRQ      = irq_q;

endmodule
